writeback: RTL

//  Final pipeline stage: consumes the registered execute->writeback bundle (e_w_WI) and load data from the data memory.

---
 rtl/writeback_pkg.sv | 44 ++++
 rtl/writeback_if.sv | 30 +++
 rtl/writeback_ld_align.sv | 32 +++
 rtl/writeback.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared types for the writeback stage: load-size encodings, FSM states,
// the execute->writeback bundle and the writeback->execute return bundle.
package writeback_pkg;

    // Load-size encodings carried in ld_spec
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } wb_state_t;

    // Registered bundle from execute
    typedef struct packed {
        logic        vld;
        logic [4:0]  rd_ind;
        logic [31:0] reg_dat;
        logic        jmp_take;
        logic [31:0] jmp_addr;
        logic        mem_rd;
        logic [1:0]  mem_lo;
        logic [2:0]  ld_spec;
    } e_w_WI;

    // Redirect returned to execute and the upstream stages
    typedef struct packed {
        logic        flush;
        logic [31:0] redir_addr;
    } w_e_WI;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/writeback_if.sv
// Execute/memory <-> writeback handshake bundle. The master side is the
// execute stage plus data memory; the slave side is the writeback stage.
interface writeback_if;

    writeback_pkg::e_w_WI e_in;
    logic                 stall_in;
    logic [31:0]          mem_rdat_in;
    logic                 mem_rvld_in;
    writeback_pkg::w_e_WI w_out;
    logic                 stall_out;

    modport master (
        output e_in,
        output stall_in,
        output mem_rdat_in,
        output mem_rvld_in,
        input  w_out,
        input  stall_out
    );

    modport slave (
        input  e_in,
        input  stall_in,
        input  mem_rdat_in,
        input  mem_rvld_in,
        output w_out,
        output stall_out
    );

endinterface

// File: rtl/writeback_ld_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of the
// word-aligned memory read data and sign- or zero-extends it.
module writeback_ld_align
    import writeback_pkg::*;
(
    input  logic [31:0] mem_rdat_in,
    input  logic [1:0]  mem_lo,
    input  logic [2:0]  ld_spec,
    output logic [31:0] o_dat
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = mem_rdat_in[8*mem_lo +: 8];
    // Halfword selection uses only the upper offset bit
    assign w_half = mem_lo[1] ? mem_rdat_in[31:16] : mem_rdat_in[15:0];

    // Extend the selected lane according to the load kind
    always_comb begin
        o_dat = mem_rdat_in;
        case (ld_spec)
            LD_LB:   o_dat = ext8(w_byte, 1'b1);
            LD_LBU:  o_dat = ext8(w_byte, 1'b0);
            LD_LH:   o_dat = ext16(w_half, 1'b1);
            LD_LHU:  o_dat = ext16(w_half, 1'b0);
            LD_LW:   o_dat = mem_rdat_in;
            default: o_dat = mem_rdat_in;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: retires instructions into the register file, completes
// loads (possibly waiting on a late memory response), raises the jump
// redirect/flush, counts retired instructions and flags memory timeouts.
module writeback
    import writeback_pkg::*;
#(
    parameter int FLUSH_CYC   = 2,
    parameter int MEM_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    writeback_if.slave  bus,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdat,
    output logic [63:0] instret,
    output logic        err_out
);

    wb_state_t   r_state;
    logic [7:0]  r_timer;
    logic [2:0]  r_fcnt;
    logic [4:0]  r_pend_rd;
    logic [1:0]  r_pend_lo;
    logic [2:0]  r_pend_spec;

    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdat;
    logic [63:0] r_instret;
    logic        r_err;
    w_e_WI       r_w_out;

    e_w_WI       w_e;
    logic        w_accept;
    logic        w_in_wait;
    logic [1:0]  w_al_lo;
    logic [2:0]  w_al_spec;
    logic [31:0] w_al_dat;

    assign w_e       = bus.e_in;
    assign w_accept  = w_e.vld & ~bus.stall_in & (r_state == IDLE);
    assign w_in_wait = (r_state == WAIT_MEM);

    // While waiting, the aligner must use the offsets captured at accept time
    assign w_al_lo   = w_in_wait ? r_pend_lo   : w_e.mem_lo;
    assign w_al_spec = w_in_wait ? r_pend_spec : w_e.ld_spec;

    writeback_ld_align u_ld_align (
        .mem_rdat_in (bus.mem_rdat_in),
        .mem_lo      (w_al_lo),
        .ld_spec     (w_al_spec),
        .o_dat       (w_al_dat)
    );

    // Writeback FSM with registered register-file, redirect and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_fcnt      <= '0;
            r_pend_rd   <= '0;
            r_pend_lo   <= '0;
            r_pend_spec <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdat   <= '0;
            r_instret   <= '0;
            r_err       <= 1'b0;
            r_w_out     <= '0;
        end else begin
            // Write enable and flush are single-cycle pulses
            r_rf_we       <= 1'b0;
            r_w_out.flush <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_e.jmp_take) begin
                            // Link write plus redirect, then squash the wrong-path window
                            r_rf_we            <= (w_e.rd_ind != 5'd0);
                            r_rf_waddr         <= w_e.rd_ind;
                            r_rf_wdat          <= w_e.reg_dat;
                            r_instret          <= r_instret + 64'd1;
                            r_w_out.flush      <= 1'b1;
                            r_w_out.redir_addr <= w_e.jmp_addr;
                            r_fcnt             <= 3'd1;
                            r_state            <= FLUSH;
                        end else if (w_e.mem_rd) begin
                            if (bus.mem_rvld_in) begin
                                r_rf_we    <= (w_e.rd_ind != 5'd0);
                                r_rf_waddr <= w_e.rd_ind;
                                r_rf_wdat  <= w_al_dat;
                                r_instret  <= r_instret + 64'd1;
                            end else begin
                                r_pend_rd   <= w_e.rd_ind;
                                r_pend_lo   <= w_e.mem_lo;
                                r_pend_spec <= w_e.ld_spec;
                                r_timer     <= 8'd1;
                                r_state     <= WAIT_MEM;
                            end
                        end else begin
                            r_rf_we    <= (w_e.rd_ind != 5'd0);
                            r_rf_waddr <= w_e.rd_ind;
                            r_rf_wdat  <= w_e.reg_dat;
                            r_instret  <= r_instret + 64'd1;
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response arriving on the timeout cycle still completes the load
                    if (bus.mem_rvld_in) begin
                        r_rf_we    <= (r_pend_rd != 5'd0);
                        r_rf_waddr <= r_pend_rd;
                        r_rf_wdat  <= w_al_dat;
                        r_instret  <= r_instret + 64'd1;
                        r_state    <= IDLE;
                    end else if (r_timer == 8'(MEM_TIMEOUT)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                FLUSH: begin
                    // Incoming bundles, including jumps, are ignored here
                    if (r_fcnt == 3'(FLUSH_CYC)) begin
                        r_state <= IDLE;
                    end else begin
                        r_fcnt <= r_fcnt + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rf_we         = r_rf_we;
    assign rf_waddr      = r_rf_waddr;
    assign rf_wdat       = r_rf_wdat;
    assign instret       = r_instret;
    assign err_out       = r_err;
    assign bus.w_out     = r_w_out;
    assign bus.stall_out = w_in_wait;

endmodule
